// File: rtl/router_pkg.sv
// router_pkg: shared state encoding and destination address constants for router_fsm
package router_pkg;
  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;
  localparam logic [1:0] ADDR_0       = 2'b00;
  localparam logic [1:0] ADDR_1       = 2'b01;
  localparam logic [1:0] ADDR_2       = 2'b10;
  localparam logic [1:0] ADDR_INVALID = 2'b11;
endpackage

// File: rtl/router_fsm.sv
// router_fsm: packet router control FSM; in: clock, resetn, pkt_valid, data_in[1:0], fifo_empty_0/1/2, fifo_full, soft_reset_0/1/2, parity_done, low_pkt_valid; out: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy
module router_fsm
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       fifo_full,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);
  state_e state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] empty_v, srst_v;
  assign empty_v = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign srst_v  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  assign addr_d  = (state_q == DECODE_ADDRESS && pkt_valid) ? data_in : addr_q;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= ADDR_0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS:
        if (pkt_valid && data_in != ADDR_INVALID)
          state_d = empty_v[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:    state_d = LOAD_DATA;
      LOAD_DATA:          state_d = fifo_full ? FIFO_FULL_STATE : (!pkt_valid ? LOAD_PARITY : LOAD_DATA);
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      FIFO_FULL_STATE:    state_d = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    state_d = parity_done ? DECODE_ADDRESS : (low_pkt_valid ? LOAD_PARITY : LOAD_DATA);
      WAIT_TILL_EMPTY:    state_d = empty_v[addr_q] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      default:            state_d = DECODE_ADDRESS;
    endcase
    if (srst_v[addr_q]) state_d = DECODE_ADDRESS;
  end
  assign detect_add    = state_q == DECODE_ADDRESS;
  assign lfd_state     = state_q == LOAD_FIRST_DATA;
  assign ld_state      = state_q == LOAD_DATA;
  assign laf_state     = state_q == LOAD_AFTER_FULL;
  assign full_state    = state_q == FIFO_FULL_STATE;
  assign rst_int_reg   = state_q == CHECK_PARITY_ERROR;
  assign write_enb_reg = ld_state || laf_state || state_q == LOAD_PARITY;
  assign busy          = !(detect_add || ld_state);
endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: table vectors, corner sequences and randomized run against a behavioural model of router_fsm
module tb_router_fsm;
  logic clock = 0, resetn = 0, pkt_valid = 0, fifo_full = 0, parity_done = 0, low_pkt_valid = 0;
  logic [1:0] data_in = 0;
  logic [2:0] empty = 0, srst = 0;
  logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy;
  logic [7:0] outs;
  int vectors = 0, miscompares = 0;
  // expected output bytes {detect_add,lfd,ld,laf,full,rst_int,write_enb,busy}
  localparam logic [7:0] P_DA = 8'b1000_0000, P_LFD = 8'b0100_0001, P_LD = 8'b0010_0010,
                         P_LP = 8'b0000_0011, P_FF = 8'b0000_1001, P_LAF = 8'b0001_0011,
                         P_WTE = 8'b0000_0001, P_CPE = 8'b0000_0101;
  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_empty_0(empty[0]), .fifo_empty_1(empty[1]), .fifo_empty_2(empty[2]),
    .fifo_full(fifo_full), .soft_reset_0(srst[0]), .soft_reset_1(srst[1]), .soft_reset_2(srst[2]),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg), .busy(busy)
  );
  assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy};
  always #5 clock = ~clock;
  typedef struct {
    logic pv; logic [1:0] din; logic [2:0] emp; logic full; logic [2:0] sr; logic pd, lpv;
    logic [7:0] exp; string name;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic pv, logic [1:0] din, logic [2:0] emp, logic full, logic [2:0] sr,
                              logic pd, logic lpv, logic [7:0] exp, string name);
    vec_t v;
    v.pv = pv; v.din = din; v.emp = emp; v.full = full; v.sr = sr; v.pd = pd; v.lpv = lpv;
    v.exp = exp; v.name = name;
    return v;
  endfunction
  task automatic chk(string name, logic [7:0] exp);
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("FAIL %s: outputs=%b expected=%b at %0t", name, outs, exp, $time);
    end
  endtask
  task automatic drive(logic pv, logic [1:0] din, logic [2:0] emp, logic full, logic [2:0] sr, logic pd, logic lpv);
    pkt_valid = pv; data_in = din; empty = emp; fifo_full = full; srst = sr; parity_done = pd; low_pkt_valid = lpv;
  endtask
  // behavioural model: packet phase names and routing rules, independent of the DUT encoding
  typedef enum int {M_IDLE, M_FIRST, M_BODY, M_PAR, M_STALL, M_RESUME, M_WAIT, M_CHECK} phase_t;
  phase_t m_ph = M_IDLE;
  int m_dest = 0;
  function automatic logic [7:0] m_out(phase_t p);
    case (p)
      M_IDLE:   return P_DA;
      M_FIRST:  return P_LFD;
      M_BODY:   return P_LD;
      M_PAR:    return P_LP;
      M_STALL:  return P_FF;
      M_RESUME: return P_LAF;
      M_WAIT:   return P_WTE;
      default:  return P_CPE;
    endcase
  endfunction
  task automatic m_step();
    phase_t n = m_ph;
    int d = int'(data_in);
    if (m_ph == M_IDLE && pkt_valid && d < 3) n = empty[d] ? M_FIRST : M_WAIT;
    if (m_ph == M_FIRST) n = M_BODY;
    if (m_ph == M_BODY) n = fifo_full ? M_STALL : (pkt_valid ? M_BODY : M_PAR);
    if (m_ph == M_PAR) n = M_CHECK;
    if (m_ph == M_CHECK) n = fifo_full ? M_STALL : M_IDLE;
    if (m_ph == M_STALL && !fifo_full) n = M_RESUME;
    if (m_ph == M_RESUME) n = parity_done ? M_IDLE : (low_pkt_valid ? M_PAR : M_BODY);
    if (m_ph == M_WAIT && empty[m_dest]) n = M_FIRST;
    if (m_dest < 3 && srst[m_dest]) n = M_IDLE;
    if (m_ph == M_IDLE && pkt_valid) m_dest = d;
    m_ph = n;
  endtask
  initial begin
    // normal packet to FIFO 1
    tbl.push_back(mk(1, 2'b01, 3'b010, 0, 0, 0, 0, P_LFD, "pkt1_lfd"));
    tbl.push_back(mk(1, 2'b01, 3'b010, 0, 0, 0, 0, P_LD,  "pkt1_ld0"));
    tbl.push_back(mk(1, 2'b01, 3'b010, 0, 0, 0, 0, P_LD,  "pkt1_ld1"));
    tbl.push_back(mk(1, 2'b01, 3'b010, 0, 0, 0, 0, P_LD,  "pkt1_ld2"));
    tbl.push_back(mk(0, 2'b01, 3'b010, 0, 0, 0, 0, P_LP,  "pkt1_lp"));
    tbl.push_back(mk(0, 2'b01, 3'b010, 0, 0, 0, 0, P_CPE, "pkt1_cpe"));
    tbl.push_back(mk(0, 2'b01, 3'b010, 0, 0, 0, 0, P_DA,  "pkt1_da"));
    // invalid header dropped
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 2'b11, 3'b111, 0, 0, 0, 0, P_DA, "bad_hdr"));
    // wait for FIFO 2, then stall on full and resume into parity
    tbl.push_back(mk(1, 2'b10, 3'b000, 0, 0, 0, 0, P_WTE, "wte_enter"));
    tbl.push_back(mk(0, 2'b10, 3'b000, 0, 0, 0, 0, P_WTE, "wte_hold"));
    tbl.push_back(mk(0, 2'b00, 3'b100, 0, 0, 0, 0, P_LFD, "wte_exit"));
    tbl.push_back(mk(1, 2'b00, 3'b000, 0, 0, 0, 0, P_LD,  "pkt2_ld"));
    tbl.push_back(mk(1, 2'b00, 3'b000, 1, 0, 0, 0, P_FF,  "full_enter"));
    tbl.push_back(mk(1, 2'b00, 3'b000, 1, 0, 0, 0, P_FF,  "full_hold"));
    tbl.push_back(mk(0, 2'b00, 3'b000, 0, 0, 0, 1, P_LAF, "laf"));
    tbl.push_back(mk(0, 2'b00, 3'b000, 0, 0, 0, 1, P_LP,  "laf_to_lp"));
    tbl.push_back(mk(0, 2'b00, 3'b000, 0, 0, 0, 0, P_CPE, "pkt2_cpe"));
    tbl.push_back(mk(0, 2'b00, 3'b000, 0, 0, 0, 0, P_DA,  "pkt2_da"));
    // soft reset: only the selected FIFO's counts
    tbl.push_back(mk(1, 2'b00, 3'b000, 0, 0,      0, 0, P_WTE, "sr_wte"));
    tbl.push_back(mk(0, 2'b00, 3'b000, 0, 3'b110, 0, 0, P_WTE, "sr_other"));
    tbl.push_back(mk(0, 2'b00, 3'b000, 0, 3'b001, 0, 0, P_DA,  "sr_sel"));
    // CHECK_PARITY_ERROR into full, resume with parity_done
    tbl.push_back(mk(1, 2'b00, 3'b001, 0, 0, 0, 0, P_LFD, "pkt3_lfd"));
    tbl.push_back(mk(1, 2'b00, 3'b001, 0, 0, 0, 0, P_LD,  "pkt3_ld"));
    tbl.push_back(mk(0, 2'b00, 3'b001, 0, 0, 0, 0, P_LP,  "pkt3_lp"));
    tbl.push_back(mk(0, 2'b00, 3'b001, 1, 0, 0, 0, P_CPE, "pkt3_cpe"));
    tbl.push_back(mk(0, 2'b00, 3'b001, 1, 0, 0, 0, P_FF,  "cpe_full"));
    tbl.push_back(mk(0, 2'b00, 3'b001, 0, 0, 1, 0, P_LAF, "pkt3_laf"));
    tbl.push_back(mk(0, 2'b00, 3'b001, 0, 0, 1, 0, P_DA,  "laf_pd"));
    // resume back into LOAD_DATA; full beats !pkt_valid; soft reset from full
    tbl.push_back(mk(1, 2'b10, 3'b100, 0, 0, 0, 0, P_LFD, "pkt4_lfd"));
    tbl.push_back(mk(1, 2'b10, 3'b100, 0, 0, 0, 0, P_LD,  "pkt4_ld"));
    tbl.push_back(mk(1, 2'b10, 3'b100, 1, 0, 0, 0, P_FF,  "pkt4_ff"));
    tbl.push_back(mk(1, 2'b10, 3'b100, 0, 0, 0, 0, P_LAF, "pkt4_laf"));
    tbl.push_back(mk(1, 2'b10, 3'b100, 0, 0, 0, 0, P_LD,  "laf_to_ld"));
    tbl.push_back(mk(0, 2'b10, 3'b100, 1, 0, 0, 0, P_FF,  "full_prio"));
    tbl.push_back(mk(0, 2'b10, 3'b100, 1, 3'b100, 0, 0, P_DA, "sr_from_ff"));
    #1 chk("reset_async", P_DA);
    @(negedge clock) chk("reset_held", P_DA);
    resetn = 1;
    foreach (tbl[i]) begin
      drive(tbl[i].pv, tbl[i].din, tbl[i].emp, tbl[i].full, tbl[i].sr, tbl[i].pd, tbl[i].lpv);
      @(posedge clock) #1 chk(tbl[i].name, tbl[i].exp);
    end
    // asynchronous reset mid LOAD_DATA
    drive(1, 2'b01, 3'b010, 0, 0, 0, 0);
    @(posedge clock) #1 chk("ar_lfd", P_LFD);
    @(posedge clock) #1 chk("ar_ld", P_LD);
    @(negedge clock) resetn = 0;
    #1 chk("ar_mid_cycle", P_DA);
    @(posedge clock) #1 chk("ar_held", P_DA);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock) resetn = 1;
    // randomized run against the model
    m_ph = M_IDLE; m_dest = 0;
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom), $urandom_range(0, 2) == 0,
            {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0},
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clock) resetn = 0;
        m_ph = M_IDLE; m_dest = 0;
        #1 chk("rand_areset", m_out(m_ph));
        @(negedge clock) resetn = 1;
      end else begin
        @(posedge clock) m_step();
        #1 chk("rand", m_out(m_ph));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
